// File: rtl/fpmul_share_ctrl_if.sv
// Requester, multiplier and response signals of the shared FP multiplier controller.
interface fpmul_share_ctrl_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_result;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, mul_result, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_result, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_result, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_result, rsp_id, busy
  );
endinterface

// File: rtl/fpmul_share_ctrl.sv
// Round-robin sharing of one fixed-latency FP multiplier with a credit-guarded result FIFO.
// Optional FPMUL_SHARE_CTRL_STATS_EN adds saturating op_count / stall_count outputs.
module fpmul_share_ctrl #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned OUT_DEPTH   = 4,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FPMUL_SHARE_CTRL_STATS_EN
  output logic [15:0] op_count,
  output logic [15:0] stall_count,
`endif
  fpmul_share_ctrl_if.slave ctrl_if
);

  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);

  logic [ID_W-1:0]  r_last_grant;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_fifo_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [MUL_LATENCY-1:0] r_tag_vld;
  logic [ID_W-1:0]  r_tag_id [MUL_LATENCY];
  logic [31:0]      r_mem_res [OUT_DEPTH];
  logic [ID_W-1:0]  r_mem_id [OUT_DEPTH];
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_result;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_busy;

  logic [ID_W-1:0]  w_scan;
  logic [ID_W-1:0]  w_grant;
  logic             w_found;
  logic             w_can_issue;
  logic             w_issue;
  logic             w_cpl;
  logic [ID_W-1:0]  w_cpl_id;
  logic             w_pop;
  logic [CNT_W-1:0] w_inflight_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_left;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [31:0]      w_head_res;
  logic [ID_W-1:0]  w_head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin scan starting just after the last granted requester
  always_comb begin
    w_found = 1'b0;
    w_grant = r_last_grant;
    w_scan  = r_last_grant;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_scan = ID_W'((32'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && ctrl_if.req_valid[w_scan]) begin
        w_found = 1'b1;
        w_grant = w_scan;
      end
    end
  end

  // Credit: every in-flight op must already own a FIFO slot
  assign w_can_issue = (SUM_W'(r_inflight) + SUM_W'(r_fifo_count)) < SUM_W'(OUT_DEPTH);
  assign w_issue     = w_found && w_can_issue && !reset;
  assign w_cpl       = r_tag_vld[MUL_LATENCY-1];
  assign w_cpl_id    = r_tag_id[MUL_LATENCY-1];
  assign w_pop       = r_rsp_valid && ctrl_if.rsp_ready;

  assign ctrl_if.req_ready = w_issue ? (NUM_REQ'(1) << w_grant) : '0;
  assign ctrl_if.mul_a     = w_issue ? ctrl_if.req_a[{w_grant, 5'd0} +: 32] : '0;
  assign ctrl_if.mul_b     = w_issue ? ctrl_if.req_b[{w_grant, 5'd0} +: 32] : '0;

  always_comb begin
    w_inflight_nxt = r_inflight;
    w_count_nxt    = r_fifo_count;
    w_left         = r_fifo_count - CNT_W'(w_pop);
    w_rd_nxt       = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_wr_nxt       = w_cpl ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_head_res     = '0;
    w_head_id      = '0;
    if (w_issue && !w_cpl) begin
      w_inflight_nxt = r_inflight + CNT_W'(1);
    end else if (!w_issue && w_cpl) begin
      w_inflight_nxt = r_inflight - CNT_W'(1);
    end
    if (w_cpl && !w_pop) begin
      w_count_nxt = r_fifo_count + CNT_W'(1);
    end else if (!w_cpl && w_pop) begin
      w_count_nxt = r_fifo_count - CNT_W'(1);
    end
    // Next head is either an already stored entry or the result being written now
    if (w_left != '0) begin
      w_head_res = r_mem_res[w_rd_nxt];
      w_head_id  = r_mem_id[w_rd_nxt];
    end else if (w_cpl) begin
      w_head_res = ctrl_if.mul_result;
      w_head_id  = w_cpl_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_inflight   <= '0;
      r_fifo_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_tag_vld    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
      r_busy       <= 1'b0;
    end else begin
      if (w_issue) begin
        r_last_grant <= w_grant;
      end
      r_tag_vld[0] <= w_issue;
      for (int i = 1; i < int'(MUL_LATENCY); i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
      end
      r_inflight   <= w_inflight_nxt;
      r_fifo_count <= w_count_nxt;
      r_wr_ptr     <= w_wr_nxt;
      r_rd_ptr     <= w_rd_nxt;
      r_rsp_valid  <= (w_count_nxt != '0);
      r_rsp_result <= w_head_res;
      r_rsp_id     <= w_head_id;
      r_busy       <= (w_inflight_nxt != '0) || (w_count_nxt != '0);
    end
  end

  // Payload storage needs no reset: validity is carried by the control state
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_grant;
    for (int i = 1; i < int'(MUL_LATENCY); i++) begin
      r_tag_id[i] <= r_tag_id[i-1];
    end
    if (w_cpl) begin
      r_mem_res[r_wr_ptr] <= ctrl_if.mul_result;
      r_mem_id[r_wr_ptr]  <= w_cpl_id;
    end
  end

  assign ctrl_if.rsp_valid  = r_rsp_valid;
  assign ctrl_if.rsp_result = r_rsp_result;
  assign ctrl_if.rsp_id     = r_rsp_id;
  assign ctrl_if.busy       = r_busy;

`ifdef FPMUL_SHARE_CTRL_STATS_EN
  logic [15:0] r_op_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_count    <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop && (r_op_count != 16'hFFFF)) begin
        r_op_count <= r_op_count + 16'd1;
      end
      if ((|ctrl_if.req_valid) && !w_can_issue && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign op_count    = r_op_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fpmul_share_ctrl.sv
// Scoreboard bench for fpmul_share_ctrl with a behavioural fixed-latency FP multiplier.
module tb_fpmul_share_ctrl;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned MUL_LATENCY = 1;
  localparam int unsigned OUT_DEPTH   = 4;
  localparam int unsigned ID_W        = 2;

  localparam logic [31:0] OP_A  [NUM_REQ] = '{32'h40000000, 32'hC0000000, 32'h3FC00000, 32'h00000000};
  localparam logic [31:0] OP_B  [NUM_REQ] = '{32'h40400000, 32'h40400000, 32'h3FC00000, 32'h40400000};
  localparam logic [31:0] EXP_P [NUM_REQ] = '{32'h40C00000, 32'hC0C00000, 32'h40100000, 32'h00000000};

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     res;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpmul_share_ctrl_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

`ifdef FPMUL_SHARE_CTRL_STATS_EN
  logic [15:0] op_count;
  logic [15:0] stall_count;
`endif

  fpmul_share_ctrl #(
    .NUM_REQ    (NUM_REQ),
    .MUL_LATENCY(MUL_LATENCY),
    .OUT_DEPTH  (OUT_DEPTH),
    .ID_W       (ID_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef FPMUL_SHARE_CTRL_STATS_EN
    .op_count   (op_count),
    .stall_count(stall_count),
`endif
    .ctrl_if    (bus)
  );

  // Truncating single-precision multiply; exact for the operands used here
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return {s, 8'(e + 1), p[46:24]};
    return {s, 8'(e), p[45:23]};
  endfunction

  logic [31:0] mpipe [MUL_LATENCY];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(MUL_LATENCY); i++) mpipe[i] <= 32'd0;
    end else begin
      mpipe[0] <= fmul(bus.mul_a, bus.mul_b);
      for (int i = 1; i < int'(MUL_LATENCY); i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign bus.mul_result = mpipe[MUL_LATENCY-1];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_pops = 0;
  int pending [NUM_REQ];
  bit lat_chk = 1'b0;
  exp_t sbq [$];
  int acc_log [$];
  int acc_cyc [$];

  logic [NUM_REQ-1:0] s_ready, s_acc;
  logic               s_rsp_valid, s_busy, s_pop;
  logic [31:0]        s_rsp_result, s_mul_a;
  logic [ID_W-1:0]    s_rsp_id;
  logic [15:0]        s_op, s_stall;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_valid();
    logic [NUM_REQ-1:0] v;
    for (int i = 0; i < int'(NUM_REQ); i++) v[i] = (pending[i] > 0);
    bus.req_valid = v;
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < int'(NUM_REQ); i++) if (pending[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: snapshot at the falling edge, score handshakes, then advance requesters
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_ready      = bus.req_ready;
    s_rsp_valid  = bus.rsp_valid;
    s_rsp_result = bus.rsp_result;
    s_rsp_id     = bus.rsp_id;
    s_busy       = bus.busy;
    s_mul_a      = bus.mul_a;
    s_acc        = bus.req_valid & bus.req_ready;
    s_pop        = bus.rsp_valid && bus.rsp_ready;
`ifdef FPMUL_SHARE_CTRL_STATS_EN
    s_op         = op_count;
    s_stall      = stall_count;
`else
    s_op         = 16'd0;
    s_stall      = 16'd0;
`endif
    if (s_pop) begin
      n_pops++;
      check("sb_nonempty_at_pop", 64'(sbq.size() > 0), 64'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        check("rsp_result", 64'(bus.rsp_result), 64'(e.res));
        if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(MUL_LATENCY + 1));
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (s_acc[i]) begin
        sbq.push_back('{id: ID_W'(i), res: EXP_P[i], cyc: cyc});
        acc_log.push_back(i);
        acc_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < int'(NUM_REQ); i++) if (s_acc[i]) pending[i]--;
    drive_valid();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < int'(NUM_REQ); i++) pending[i] = 0;
    drive_valid();
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
    acc_log.delete();
    acc_cyc.delete();
    lat_chk = 1'b0;
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    bus.rsp_ready = 1'b1;
    while ((sbq.size() != 0 || any_pending() || s_busy) && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_sb_empty"}, 64'(sbq.size()), 64'd0);
    check({tag, "_busy_idle"}, 64'(s_busy), 64'd0);
    check({tag, "_rsp_valid_idle"}, 64'(s_rsp_valid), 64'd0);
  endtask

  initial begin
    int p0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.req_a[32*i +: 32] = OP_A[i];
      bus.req_b[32*i +: 32] = OP_B[i];
      pending[i] = 0;
    end

    // Reset state
    do_reset();
    tick();
    check("rst_rsp_valid", 64'(s_rsp_valid), 64'd0);
    check("rst_rsp_result", 64'(s_rsp_result), 64'd0);
    check("rst_rsp_id", 64'(s_rsp_id), 64'd0);
    check("rst_busy", 64'(s_busy), 64'd0);
    check("rst_req_ready", 64'(s_ready), 64'd0);
    check("rst_mul_a", 64'(s_mul_a), 64'd0);

    // Single op 2.0 x 3.0
    do_reset();
    lat_chk = 1'b1;
    bus.rsp_ready = 1'b1;
    pending[0] = 1;
    drive_valid();
    p0 = n_pops;
    drain("single", 20);
    check("single_pops", 64'(n_pops - p0), 64'd1);

    // Fairness with all requesters valid
    do_reset();
    lat_chk = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < int'(NUM_REQ); i++) pending[i] = 2;
    drive_valid();
    drain("fair", 40);
    check("fair_accepts", 64'(acc_log.size()), 64'd8);
    if (acc_log.size() == 8) begin
      for (int k = 0; k < 8; k++) check("fair_grant", 64'(acc_log[k]), 64'(k % NUM_REQ));
      check("fair_back_to_back", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
    end

    // Backpressure
    do_reset();
    for (int i = 0; i < int'(NUM_REQ); i++) pending[i] = 3;
    drive_valid();
    repeat (8) tick();
    check("bp_accepts", 64'(acc_log.size()), 64'(OUT_DEPTH));
    check("bp_ready_zero", 64'(s_ready), 64'd0);
    check("bp_rsp_valid", 64'(s_rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_pop", 64'(s_pop), 64'd1);
    check("bp_no_acc_on_pop", 64'(s_acc), 64'd0);
    bus.rsp_ready = 1'b0;
    tick();
    check("bp_one_acc", 64'($countones(s_acc)), 64'd1);
    tick();
    check("bp_total", 64'(acc_log.size()), 64'(OUT_DEPTH + 1));
    drain("bp", 80);

    // Sign and zero operands
    do_reset();
    lat_chk = 1'b1;
    bus.rsp_ready = 1'b1;
    pending[1] = 1;
    pending[3] = 1;
    drive_valid();
    p0 = n_pops;
    drain("signzero", 20);
    check("signzero_pops", 64'(n_pops - p0), 64'd2);

    // Reset while ops are in flight
    do_reset();
    for (int i = 0; i < 3; i++) pending[i] = 1;
    drive_valid();
    repeat (3) tick();
    check("rf_accepts", 64'(acc_log.size()), 64'd3);
    pending[3] = 1;
    drive_valid();
    reset = 1'b1;
    sbq.delete();
    tick();
    check("rf_no_accept_in_reset", 64'(s_ready), 64'd0);
    reset = 1'b0;
    pending[0] = 1;
    drive_valid();
    acc_log.delete();
    p0 = n_pops;
    tick();
    check("rf_rsp_valid", 64'(s_rsp_valid), 64'd0);
    check("rf_busy", 64'(s_busy), 64'd0);
    check("rf_rr_winner", 64'(s_acc), 64'd1);
    drain("rf", 40);
    check("rf_pops", 64'(n_pops - p0), 64'd2);

`ifdef FPMUL_SHARE_CTRL_STATS_EN
    // Statistics counters under backpressure
    do_reset();
    tick();
    check("st_rst_op", 64'(s_op), 64'd0);
    check("st_rst_stall", 64'(s_stall), 64'd0);
    for (int i = 0; i < int'(NUM_REQ); i++) pending[i] = 3;
    drive_valid();
    p0 = n_pops;
    repeat (15) tick();
    check("st_stall_count", 64'(s_stall), 64'd10);
    drain("st", 100);
    check("st_op_count", 64'(s_op), 64'(n_pops - p0));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpmul_share_ctrl.md
Name: fpmul_share_ctrl

Overview:
- Shares one single-precision FP multiplier datapath among NUM_REQ requesters.
- The multiplier has a fixed latency, a registered result and no stall input.
- Per-requester valid/ready request ports feed a round-robin arbiter; at most one operation issues per cycle.
- Each in-flight op is tagged with its requester ID. Results drain through an output FIFO with valid/ready, and a credit counter ensures the FIFO never overflows.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MUL_LATENCY, 1: cycles from operands on mul_a/mul_b to result on mul_result, 1..4.
- OUT_DEPTH, 4: output FIFO entries; must be >= MUL_LATENCY+1.
- ID_W, $clog2(NUM_REQ): requester ID width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; also routed to the multiplier.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  32*NUM_REQ  operand A, requester i at [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing.
- mul_a  out  32  operand A to the multiplier.
- mul_b  out  32  operand B to the multiplier.
- mul_result  in  32  multiplier result.
- rsp_valid  out  1  output FIFO head valid.
- rsp_ready  in  1  consumer accept.
- rsp_result  out  32  product at the FIFO head.
- rsp_id  out  ID_W  requester ID at the FIFO head.
- busy  out  1  high if any op is in flight or the FIFO is non-empty.

Behaviour:
- Reset values (registered state):
  - rsp_valid=0, rsp_result=0, rsp_id=0, busy=0.
  - FIFO pointers and count = 0; credit/in-flight count = 0; tag pipeline valids = 0.
  - RR pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation: all in-flight ops and FIFO contents are discarded, with no response. Requests held during reset are not accepted.
- Issue condition: can_issue = (inflight + fifo_count) < OUT_DEPTH. inflight counts ops issued but not yet written to the FIFO.
- Arbitration:
  - Combinational round-robin over req_valid, starting at last_grant+1 and wrapping modulo NUM_REQ.
  - grant = first valid requester found, qualified by can_issue.
  - req_ready[grant]=1; all other req_ready bits are 0. req_ready may depend on req_valid.
  - last_grant updates to grant only on an issue cycle; otherwise it holds.
- Issue (req_valid[g] && req_ready[g]):
  - mul_a/mul_b = req_a/req_b slice g in that cycle; both are 0 when nothing issues.
  - A tag {valid=1, id=g} enters a MUL_LATENCY-deep shift register.
- Completion:
  - When the tag pipeline output is valid, mul_result is sampled in that same cycle. The cycle is exactly MUL_LATENCY after issue.
  - The result is written with its id into the FIFO tail; inflight decrements.
  - Issue and completion in the same cycle leave inflight unchanged.
- Output FIFO:
  - rsp_* present the head entry. Pop occurs on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full (pop frees the slot) or empty (write-through is not required; the entry appears the next cycle).
  - Results are delivered in issue order.
- Throughput: with rsp_ready held at 1, one op issues per cycle sustained. Request-to-response latency is MUL_LATENCY+1 cycles.
- Backpressure: with rsp_ready=0, exactly OUT_DEPTH ops are accepted, then req_ready stays 0 until a pop.
- Pointers wrap modulo OUT_DEPTH; OUT_DEPTH need not be a power of two.
- Requesters must hold req_valid and operands stable until accepted. The controller does not check this.
- busy = (inflight != 0) || (fifo_count != 0), registered.

Optional Feature:
- Macro: FPMUL_SHARE_CTRL_STATS_EN.
- When defined:
  - Adds output port op_count (16 bits): a saturating count of FIFO pops, cleared by reset, holding at 0xFFFF.
  - Adds output port stall_count (16 bits): a saturating count of cycles with any req_valid high and can_issue=0.
- When undefined: neither port nor their logic exists; all other behaviour is identical.

Test Plan:
- Single op: requester 0 sends 0x40000000 x 0x40400000 (2.0 x 3.0), rsp_ready=1. Expect rsp_valid two cycles after acceptance (MUL_LATENCY=1), rsp_result=0x40C00000, rsp_id=0; busy then returns to 0.
- Fairness: all 4 requesters valid continuously with distinct operands. Expect grant order 0,1,2,3,0,1,... and one issue per cycle. Responses return in the same ID order; requester 2's op 0x3FC00000 x 0x3FC00000 yields 0x40100000.
- Backpressure: rsp_ready=0 with all requesters valid. Expect exactly 4 accepts, then req_ready=0. Raise rsp_ready for 1 cycle: one pop, then one new accept the following cycle.
- Sign/zero: requester 1 sends 0xC0000000 x 0x40400000, expect 0xC0C00000. Requester 3 sends 0x00000000 x 0x40400000, expect exponent/mantissa fields 0.
- Reset mid-flight: issue 3 ops, assert reset for 1 cycle before any pop. Expect rsp_valid=0, busy=0 and no stale responses afterwards. The next request from requester 0 wins over a simultaneous one from requester 3.
- Stats (macro defined): run the backpressure case for 10 stalled cycles, then drain. Expect stall_count=10 and op_count equal to the number of pops.
